// File: rtl/cpen391_pio_pkg.sv
// Shared definitions for the CPEN391 parallel-input status ports:
// register map, edge-capture encodings and small helpers.
package cpen391_pio_pkg;

    // Avalon-MM word addresses of the PIO register file
    typedef enum logic [1:0] {
        ADDR_DATA     = 2'd0,
        ADDR_UNUSED   = 2'd1,
        ADDR_IRQ_MASK = 2'd2,
        ADDR_EDGE_CAP = 2'd3
    } pio_addr_e;

    // Encodings for the EDGE_TYPE parameter
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Cycles after reset release during which the input baseline is
    // established and edge detection stays quiet.
    localparam int WARMUP_CYCLES = 3;

    // Decoded bus request for one cycle
    typedef struct packed {
        logic      rd;
        logic      wr;
        pio_addr_e addr;
    } pio_req_t;

    // Counter width able to hold 0..d (at least one bit)
    function automatic int cnt_width(int d);
        return (d < 1) ? 1 : $clog2(d + 1);
    endfunction

    // Per-bit qualifying transitions between previous and current level
    function automatic logic [31:0] edge_hits(logic [31:0] cur,
                                              logic [31:0] prev,
                                              int          edge_type);
        logic [31:0] hits;
        case (edge_type)
            EDGE_RISING:  hits = cur & ~prev;
            EDGE_FALLING: hits = ~cur & prev;
            default:      hits = cur ^ prev;
        endcase
        return hits;
    endfunction

endpackage

// File: rtl/wifi_status_pio_in_if.sv
// Avalon-MM slave bus plus interrupt line of the WiFi status input port.
interface wifi_status_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_in_debounce.sv
// One status line: 2-flop synchronizer followed by an optional
// stability filter that only accepts a new level after it has been
// held for DEBOUNCE_CYCLES consecutive cycles.
module pio_in_debounce
    import cpen391_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic seed,      // load stable directly from the synchronizer
    input  logic din,       // asynchronous line
    output logic sync_out,  // synchronized level (sync2)
    output logic stable     // filtered level
);

    logic sync1;
    logic sync2;

    // metastability guard for the asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    assign sync_out = sync2;

    if (DEBOUNCE_CYCLES == 0) begin : g_pass
        // without a filter the seed window changes nothing
        logic unused_seed;
        assign unused_seed = seed;

        // stable follows the synchronizer one cycle later
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) stable <= 1'b0;
            else          stable <= sync2;
        end
    end else begin : g_filt
        localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic          sync2_q;
        logic [CW-1:0] cnt;

        // count consecutive cycles of an unchanged level that differs from
        // stable; the D-th such cycle accepts the level. The counter is
        // cleared on acceptance, so it never passes LAST and cannot wrap.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync2_q <= 1'b0;
                cnt     <= '0;
                stable  <= 1'b0;
            end else begin
                sync2_q <= sync2;
                if (seed) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else if (sync2 == stable || sync2 != sync2_q) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/wifi_status_pio_in.sv
// WiFi module status input port: synchronized/debounced status lines,
// edge capture with write-1-to-clear, interrupt mask and a level irq,
// all behind a four-word Avalon-MM slave with read latency 1.
module wifi_status_pio_in
    import cpen391_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = EDGE_RISING,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    in_port,
    wifi_status_pio_in_if.slave bus
);

    logic [WARMUP_CYCLES-1:0] vld_pipe;
    logic                     armed;
    logic                     seed;

    logic [WIDTH-1:0] sync_vec;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr_mask;
    logic [31:0]      rd_val;
    logic [31:0]      readdata_q;
    pio_req_t         req;

    // only the low WIDTH bits of writedata reach a register
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    // warm-up shift register: fills with ones after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[WARMUP_CYCLES-2:0], 1'b1};
    end

    // Until the pipe is full the level seen on the lines is taken as the
    // baseline (stable and its previous copy both load sync2), so a line
    // already high at reset release never looks like an edge.
    assign armed = vld_pipe[WARMUP_CYCLES-1];
    assign seed  = ~armed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .seed    (seed),
            .din     (in_port[i]),
            .sync_out(sync_vec[i]),
            .stable  (stable[i])
        );
    end

    // previous-cycle copy of stable for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  stable_q <= '0;
        else if (seed) stable_q <= sync_vec;
        else           stable_q <= stable;
    end

    // decode the bus strobes into a request
    always_comb begin
        req      = '0;
        req.rd   = bus.chipselect & ~bus.read_n;
        req.wr   = bus.chipselect & ~bus.write_n;
        req.addr = pio_addr_e'(bus.address);
    end

    assign edge_hit = armed ? WIDTH'(edge_hits(32'(stable), 32'(stable_q), EDGE_TYPE))
                            : '0;
    assign clr_mask = (req.wr && req.addr == ADDR_EDGE_CAP) ? bus.writedata[WIDTH-1:0]
                                                            : '0;

    // sticky edge capture; a new edge beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cap <= '0;
        else          edge_cap <= (edge_cap & ~clr_mask) | edge_hit;
    end

    // interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                 irq_mask <= '0;
        else if (req.wr && req.addr == ADDR_IRQ_MASK) irq_mask <= bus.writedata[WIDTH-1:0];
    end

    // read mux over the current (pre-write) register values
    always_comb begin
        rd_val = '0;
        case (req.addr)
            ADDR_DATA:     rd_val[WIDTH-1:0] = stable;
            ADDR_IRQ_MASK: rd_val[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_val[WIDTH-1:0] = edge_cap;
            default:       rd_val = '0;
        endcase
    end

    // registered read data, held until the next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    readdata_q <= '0;
        else if (req.rd) readdata_q <= rd_val;
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_wifi_status_pio_in.sv
// Bench for wifi_status_pio_in: four configurations share one bus and one
// set of status lines; each is tracked by a cycle-level reference model,
// with a hand-checked vector table and directed corner sequences on top.
module tb_wifi_status_pio_in;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata;
    logic [31:0] rdata [N];
    logic        irq_v [N];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // 0: rising, 1: any edge, 2: rising with 8-cycle debounce, 3: falling
    function automatic int et_of(int g);
        return (g == 1) ? 2 : (g == 3) ? 1 : 0;
    endfunction
    function automatic int dc_of(int g);
        return (g == 2) ? 8 : 0;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        wifi_status_pio_in_if bus ();
        assign bus.address    = address;
        assign bus.chipselect = chipselect;
        assign bus.read_n     = read_n;
        assign bus.write_n    = write_n;
        assign bus.writedata  = writedata;
        assign rdata[g]       = bus.readdata;
        assign irq_v[g]       = bus.irq;

        wifi_status_pio_in #(
            .WIDTH(4), .EDGE_TYPE(et_of(g)), .DEBOUNCE_CYCLES(dc_of(g))
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus)
        );
    end

    // ---------------- reference model ----------------
    logic [3:0]  hist[$];        // hist[e] = in_port sampled at edge e
    int          ecnt;
    logic [3:0]  m_stable [N];
    logic [3:0]  m_prev   [N];
    logic [3:0]  m_cap    [N];
    logic [3:0]  m_mask   [N];
    logic [31:0] m_rd     [N];

    function automatic logic [3:0] h(int i);
        return (i < 1) ? 4'h0 : hist[i];
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(4'h0);
        ecnt = 0;
        for (int k = 0; k < N; k++) begin
            m_stable[k] = '0; m_prev[k] = '0; m_cap[k] = '0;
            m_mask[k] = '0;   m_rd[k] = '0;
        end
    endtask

    // one clock edge; reads the inputs that were present at the edge
    task automatic model_step();
        logic rd, wr;
        ecnt++;
        hist.push_back(in_port);
        rd = chipselect & ~read_n;
        wr = chipselect & ~write_n;
        for (int k = 0; k < N; k++) begin
            logic [3:0] s2, nst, npv, hit, clr, smp;
            int d;
            d  = dc_of(k);
            s2 = h(ecnt - 2);     // synchronized level just before this edge
            if (ecnt <= 3) begin
                nst = s2; npv = s2;
            end else begin
                npv = m_stable[k];
                nst = m_stable[k];
                if (d == 0) nst = s2;
                else begin
                    // accept a level once the last d+1 synchronized samples agree
                    for (int b = 0; b < 4; b++) begin
                        logic want;
                        bit   all_eq;
                        want   = ~m_stable[k][b];
                        all_eq = 1'b1;
                        for (int j = ecnt - 2 - d; j <= ecnt - 2; j++) begin
                            smp = h(j);
                            if (smp[b] != want) all_eq = 1'b0;
                        end
                        if (all_eq) nst[b] = want;
                    end
                end
            end
            case (et_of(k))
                0:       hit = m_stable[k] & ~m_prev[k];
                1:       hit = ~m_stable[k] & m_prev[k];
                default: hit = m_stable[k] ^ m_prev[k];
            endcase
            if (ecnt < 4) hit = 4'h0;
            clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
            if (rd) begin
                case (address)
                    2'd0:    m_rd[k] = {28'h0, m_stable[k]};
                    2'd2:    m_rd[k] = {28'h0, m_mask[k]};
                    2'd3:    m_rd[k] = {28'h0, m_cap[k]};
                    default: m_rd[k] = 32'h0;
                endcase
            end
            m_cap[k] = (m_cap[k] & ~clr) | hit;
            if (wr && address == 2'd2) m_mask[k] = writedata[3:0];
            m_stable[k] = nst;
            m_prev[k]   = npv;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_chk();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("model dut%0d readdata", k), rdata[k], m_rd[k]);
            chk($sformatf("model dut%0d irq", k), {31'h0, irq_v[k]},
                {31'h0, |(m_cap[k] & m_mask[k])});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        model_chk();
    endtask

    task automatic cyc(int n);
        repeat (n) tick();
    endtask

    task automatic bus_op(logic rd, logic wr, logic [1:0] a, logic [31:0] d);
        chipselect = rd | wr;
        read_n     = ~rd;
        write_n    = ~wr;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    endtask

    task automatic do_reset(int hold);
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("reset dut%0d readdata", k), rdata[k], 32'h0);
            chk($sformatf("reset dut%0d irq", k), {31'h0, irq_v[k]}, 32'h0);
        end
        cyc(hold);
        reset_n = 1'b1;
    endtask

    // ---------------- hand-derived vector table (config 0) ----------------
    typedef struct {
        logic [3:0]  in;
        int          pre;
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    function automatic vec_t mk(logic [3:0] in, int pre, logic rd, logic wr,
                                logic [1:0] a, logic [31:0] wd,
                                logic [31:0] exp_rd, logic exp_irq);
        vec_t v;
        v.in = in; v.pre = pre; v.rd = rd; v.wr = wr; v.addr = a;
        v.wd = wd; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        return v;
    endfunction

    vec_t tv [16];

    initial begin
        tv[0]  = mk(4'hF, 5, 1, 0, 2'd0, 32'h0,        32'hF, 1'b0); // data after reset
        tv[1]  = mk(4'hF, 0, 1, 0, 2'd3, 32'h0,        32'h0, 1'b0); // no false edge
        tv[2]  = mk(4'hF, 0, 0, 1, 2'd2, 32'h2,        32'h0, 1'b0); // mask = 2
        tv[3]  = mk(4'hD, 4, 1, 0, 2'd0, 32'h0,        32'hD, 1'b0); // bit1 low
        tv[4]  = mk(4'hF, 4, 1, 0, 2'd3, 32'h0,        32'h2, 1'b1); // bit1 rises
        tv[5]  = mk(4'hF, 0, 0, 1, 2'd3, 32'h2,        32'h2, 1'b0); // W1C bit1
        tv[6]  = mk(4'hF, 0, 1, 0, 2'd3, 32'h0,        32'h0, 1'b0);
        tv[7]  = mk(4'hF, 0, 0, 1, 2'd0, 32'hFFFFFFFF, 32'h0, 1'b0); // data is RO
        tv[8]  = mk(4'hF, 0, 0, 1, 2'd1, 32'h5,        32'h0, 1'b0);
        tv[9]  = mk(4'hF, 0, 1, 0, 2'd0, 32'h0,        32'hF, 1'b0);
        tv[10] = mk(4'hF, 0, 1, 0, 2'd1, 32'h0,        32'h0, 1'b0);
        tv[11] = mk(4'hF, 0, 1, 1, 2'd2, 32'hF,        32'h2, 1'b0); // read old mask
        tv[12] = mk(4'hF, 0, 1, 0, 2'd2, 32'h0,        32'hF, 1'b0);
        tv[13] = mk(4'hE, 4, 1, 0, 2'd0, 32'h0,        32'hE, 1'b0); // bit0 falls
        tv[14] = mk(4'hF, 3, 0, 1, 2'd3, 32'h1,        32'hE, 1'b1); // set beats W1C
        tv[15] = mk(4'hF, 0, 1, 0, 2'd3, 32'h0,        32'h1, 1'b1);

        in_port = 4'hF;
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0;
        reset_n = 1'b0;
        @(negedge clk);
        do_reset(3);

        for (int i = 0; i < 16; i++) begin
            in_port = tv[i].in;
            cyc(tv[i].pre);
            bus_op(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wd);
            tick();
            chk($sformatf("vec%0d readdata", i), rdata[0], tv[i].exp_rd);
            chk($sformatf("vec%0d irq", i), {31'h0, irq_v[0]}, {31'h0, tv[i].exp_irq});
        end

        // any-edge config: falling bit3 captured, irq held off by zero mask
        bus_op(0, 1, 2'd2, 32'h0);
        bus_op(0, 1, 2'd3, 32'hF);
        in_port = 4'h7;
        cyc(5);
        bus_op(1, 0, 2'd3, 32'h0);
        tick();
        chk("any-edge capture", rdata[1], 32'h8);
        cyc(3);
        chk("any-edge irq masked", {31'h0, irq_v[1]}, 32'h0);

        // debounce config: short pulse rejected, long pulse accepted on time
        in_port = 4'hB;
        cyc(20);
        bus_op(0, 1, 2'd3, 32'hF);
        in_port = 4'hF;
        cyc(5);
        in_port = 4'hB;
        cyc(20);
        bus_op(1, 0, 2'd0, 32'h0);
        tick();
        chk("short pulse data", rdata[2], 32'hB);
        bus_op(1, 0, 2'd3, 32'h0);
        tick();
        chk("short pulse capture", rdata[2], 32'h0);
        in_port = 4'hF;
        cyc(9);
        bus_op(1, 0, 2'd0, 32'h0);
        tick();
        chk("long pulse before accept", rdata[2], 32'hB);
        bus_op(1, 0, 2'd0, 32'h0);
        tick();
        chk("long pulse accepted", rdata[2], 32'hF);
        bus_op(1, 0, 2'd3, 32'h0);
        tick();
        chk("long pulse capture", rdata[2], 32'h4);

        // randomized traffic against the model, with occasional resets
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] flip;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 15) == 0);
            in_port ^= flip;
            if ($urandom_range(0, 249) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                read_n     = 1'($urandom_range(0, 1));
                write_n    = 1'($urandom_range(0, 1));
                address    = 2'($urandom_range(0, 3));
                writedata  = $urandom;
                tick();
                chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wifi_status_pio_in.md
WIFI_STATUS_PIO_IN -- requirements
Module: wifi_status_pio_in

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of input status lines (1..32).
REQ-002 SHALL have parameter EDGE_TYPE, default 0: capture edge (0 rising, 1 falling, 2 any).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 0: required stable cycles before an input change is accepted (0 = no filter).
REQ-004 clk  input  1  clock; all state on posedge clk.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 read_n  input  1  active-low read strobe.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  read data, read latency 1.
REQ-012 in_port  input  WIDTH  asynchronous status lines from the WiFi module.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 SHALL pass each in_port bit through a 2-flop synchronizer (sync1, sync2).
REQ-015 With DEBOUNCE_CYCLES=0, stable register SHALL load sync2 every cycle; in_port sampled at edge k appears in stable after edge k+2.
REQ-016 With DEBOUNCE_CYCLES=D>0, per-bit counter (width clog2(D+1)) SHALL clear whenever sync2 equals stable or sync2 changed since last cycle, increment while sync2 differs from stable and is unchanged, and load stable with sync2 when count reaches D; counter saturates, never wraps.
REQ-017 Edge detect SHALL compare stable to its previous-cycle copy; per EDGE_TYPE a qualifying transition sets the matching edge_capture bit on the following edge.
REQ-018 Register map: addr 0 data = stable (RO); addr 1 reads 0, writes ignored; addr 2 irq_mask (RW, WIDTH bits); addr 3 edge_capture (read; write-1-to-clear per bit).
REQ-019 Unused upper readdata bits (WIDTH..31) SHALL read 0.
REQ-020 Read: chipselect & ~read_n at edge n SHALL drive the addressed value on readdata after edge n+1 and hold until the next read; reads have no side effects.
REQ-021 Write: chipselect & ~write_n at edge n SHALL update the target register at edge n; writes to addr 0 and 1 ignored.
REQ-022 Simultaneous new edge and W1C on the same bit SHALL leave the bit set (set wins).
REQ-023 irq SHALL equal OR of (edge_capture & irq_mask), combinational from registers, no extra latency.
REQ-024 Simultaneous read and write of same register: readdata SHALL return the pre-write value.
REQ-025 Asserting chipselect with both read_n and write_n low SHALL perform both per REQ-020/021/024.

Reset
REQ-026 reset_n low SHALL asynchronously clear sync1, sync2, stable, previous copy, debounce counters, edge_capture, irq_mask, readdata; irq reads 0.
REQ-027 After reset release, in_port high SHALL NOT set edge_capture for rising edge (previous copy tracks stable from reset value 0 only after first sync); implementation SHALL suppress edge detection for the first 3 cycles after reset release.
REQ-028 Reset mid-debounce SHALL discard partial counts.

Structure
REQ-029 Register address constants (DATA=0, UNUSED=1, IRQ_MASK=2, EDGE_CAP=3) and EDGE_TYPE encodings SHALL live in shared package cpen391_pio_pkg.
REQ-030 Per-bit synchronizer+debounce SHALL be one sub-module, pio_in_debounce, instantiated WIDTH times via generate.

Verification
REQ-031 Reset, in_port=4'hF held; read addr 0 after 5 cycles -> readdata=32'h0000000F; read addr 3 -> 0; irq=0.
REQ-032 EDGE_TYPE=0, mask=4'h2, in_port bit1 0->1 -> edge_capture=4'h2 within 4 cycles, irq=1; write addr 3 =32'h2 -> capture 0, irq=0 next cycle.
REQ-033 Rising edge on bit0 same cycle as W1C of bit0 -> edge_capture bit0 stays 1.
REQ-034 DEBOUNCE_CYCLES=8, 5-cycle pulse on bit2 -> data and capture unchanged; 12-cycle pulse -> data bit2=1 after 2+8 cycles.
REQ-035 EDGE_TYPE=2, bit3 toggles 1->0 -> capture bit3=1; mask=0 -> irq stays 0.
REQ-036 Write addr 0 =32'hFFFFFFFF, addr 1 =32'h5 -> reads return unchanged data and 0 respectively.
